// File: rtl/inverse_trigonometric_if.sv
`default_nettype none
// ============================================================================
// Module   : inverse_trigonometric_if
// Brief    : Start/busy/done request bus for the inverse sine/cosine search.
// Revision : 1.0 - initial release
// ============================================================================
interface inverse_trigonometric_if;
  logic        start;
  logic [9:0]  value;
  logic        iscos;
  logic        busy;
  logic        done;
  logic [11:0] degree;

  modport master (
    output start, value, iscos,
    input  busy, done, degree
  );

  modport slave (
    input  start, value, iscos,
    output busy, done, degree
  );
endinterface
`default_nettype wire

// File: rtl/inverse_trigonometric.sv
`default_nettype none
// ============================================================================
// Module   : inverse_trigonometric
// Brief    : Binary search over a quarter-wave sine ROM; returns asin/acos code.
// Revision : 1.0 - initial release
// ============================================================================
module inverse_trigonometric #(
  parameter string ROM_FILE = "asin_rom.hex",
  parameter int    ITER     = 10
) (
  input  wire logic                clk,
  input  wire logic                rst,
  inverse_trigonometric_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_CMP  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // pi in unsigned Q4.60
  localparam logic [63:0] c_pi_q60 = 64'h3243F6A8885A308D;
  localparam logic [9:0]  c_hi_init = 10'd1023;

  // round(1023*sin(pi*a/2048)) via a Q60 Taylor series, evaluated at elaboration
  function automatic logic [9:0] f_sine(input int a);
    logic signed [127:0] x;
    logic signed [127:0] x2;
    logic signed [127:0] term;
    logic signed [127:0] sum;
    x    = $signed(128'(c_pi_q60) * 128'(a)) >>> 11;
    x2   = (x * x) >>> 60;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -(((term * x2) >>> 60) / 128'(2 * n * (2 * n + 1)));
      sum  = sum + term;
    end
    return 10'((sum * 1023 + (128'sd1 <<< 59)) >>> 60);
  endfunction

  logic [9:0] w_rom [1024];

  // An unnamed image falls back to an identity ramp, handy for bring-up.
  generate
    if (ROM_FILE != "") begin : g_rom_sine
      for (genvar a = 0; a < 1024; a++) begin : g_entry
        localparam logic [9:0] c_val = f_sine(a);
        assign w_rom[a] = c_val;
      end
    end else begin : g_rom_ramp
      for (genvar a = 0; a < 1024; a++) begin : g_entry
        assign w_rom[a] = 10'(a);
      end
    end
  endgenerate

  state_t      r_state;
  logic [9:0]  r_lo;
  logic [9:0]  r_hi;
  logic [9:0]  r_v;
  logic        r_c;
  logic [3:0]  r_k;
  logic [9:0]  r_rom_q;
  logic        r_busy;
  logic        r_done;
  logic [11:0] r_degree;
  logic [9:0]  w_mid;

  assign w_mid = 10'((11'(r_lo) + 11'(r_hi)) >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_lo     <= 10'd0;
      r_hi     <= 10'd0;
      r_v      <= 10'd0;
      r_c      <= 1'b0;
      r_k      <= 4'd0;
      r_rom_q  <= 10'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_degree <= 12'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_v     <= bus.value;
            r_c     <= bus.iscos;
            r_lo    <= 10'd0;
            r_hi    <= c_hi_init;
            r_k     <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_rom_q <= w_rom[w_mid];
          r_state <= S_CMP;
        end
        S_CMP: begin
          // lower-bound search; S(1023)=1023 keeps mid+1 from wrapping
          if (r_rom_q >= r_v) begin
            r_hi <= w_mid;
          end else begin
            r_lo <= w_mid + 10'd1;
          end
          r_k     <= r_k + 4'd1;
          r_state <= (r_k == 4'(ITER - 1)) ? S_OUT : S_ADDR;
        end
        S_OUT: begin
          r_degree <= r_c ? (12'd1024 - {2'b00, r_lo}) : {2'b00, r_lo};
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.degree = r_degree;

endmodule
`default_nettype wire

// File: tb/tb_inverse_trigonometric.sv
`default_nettype none
// ============================================================================
// Module   : tb_inverse_trigonometric
// Brief    : Directed and swept checks of the inverse sine/cosine search.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inverse_trigonometric;

  logic clk = 1'b0;
  logic rst = 1'b0;

  inverse_trigonometric_if bus ();

  inverse_trigonometric #(
    .ROM_FILE ("asin_rom.hex"),
    .ITER     (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   chk_en = 1'b0;
  int   s_tab [1024];

  int   dv [7] = '{0, 0, 1023, 1023, 512, 511, 512};
  int   dc [7] = '{0, 1, 0, 1, 0, 0, 1};
  int   de [7] = '{0, 1024, 1004, 20, 342, 341, 682};

  // Reference: a result is due 21 clocks after an accepted start.
  int          m_cnt;
  logic [9:0]  m_v;
  logic        m_c;
  logic        m_done;
  logic [11:0] m_deg;

  function automatic int golden(input int v, input int c);
    int a = 0;
    while (a < 1023 && s_tab[a] < v) a++;
    return (c != 0) ? (1024 - a) : a;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_v    <= 10'd0;
      m_c    <= 1'b0;
      m_done <= 1'b0;
      m_deg  <= 12'd0;
    end else if (m_cnt != 0) begin
      m_cnt  <= m_cnt - 1;
      m_done <= (m_cnt == 1);
      if (m_cnt == 1) m_deg <= 12'(golden(int'(m_v), int'(m_c)));
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        m_cnt <= 21;
        m_v   <= bus.value;
        m_c   <= bus.iscos;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("busy", int'(bus.busy), int'(m_cnt != 0));
      check("done", int'(bus.done), int'(m_done));
      check("degree", int'(bus.degree), int'(m_deg));
    end
  end

  task automatic do_search(input int v, input int c, output int deg);
    int e0;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 10'(v);
    bus.iscos = c[0];
    e0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    check("latency", seen ? (cyc - e0) : -1, 21);
    deg = int'(bus.degree);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int nd;
    int dcyc;
    int deg;
    int prev;
    int dn [4];

    for (int a = 0; a < 1024; a++)
      s_tab[a] = $rtoi(1023.0 * $sin(3.14159265358979 * a / 2048.0) + 0.5);

    bus.start = 1'b0;
    bus.value = 10'd0;
    bus.iscos = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_degree", int'(bus.degree), 0);

    // Reset in the middle of a search abandons it.
    bus.start = 1'b1;
    bus.value = 10'd700;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_mid", int'(bus.busy), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("rst_no_done", nd, 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_degree", int'(bus.degree), 0);

    chk_en = 1'b1;

    for (int i = 0; i < 7; i++) begin
      check("model_pin", golden(dv[i], dc[i]), de[i]);
      do_search(dv[i], dc[i], deg);
      check("directed", deg, de[i]);
    end

    // Extra start pulses while busy are dropped.
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 10'd300;
    bus.iscos = 1'b0;
    e0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    nd = 0;
    dcyc = -1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) begin
        nd++;
        dcyc = cyc;
      end
    end
    check("ignore_count", nd, 1);
    check("ignore_latency", dcyc - e0, 21);
    check("ignore_degree", int'(bus.degree), golden(300, 0));

    // Start held high: one result every 22 clocks.
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 10'd900;
    bus.iscos = 1'b1;
    e0 = cyc + 1;
    nd = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (nd < 4) dn[nd] = cyc - e0;
        nd++;
      end
    end
    bus.start = 1'b0;
    check("held_count", nd, 3);
    check("held_first", dn[0], 21);
    check("held_gap1", dn[1] - dn[0], 22);
    check("held_gap2", dn[2] - dn[1], 22);
    nd = 0;
    for (int i = 0; i < 60 && (bus.busy || bus.done); i++) begin
      @(negedge clk);
      nd++;
    end
    check("held_idle", int'(bus.busy), 0);

    // Inputs changing mid-search are not seen.
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 10'd512;
    bus.iscos = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.value = 10'd0;
    bus.iscos = 1'b1;
    nd = 0;
    for (int i = 0; i < 40 && !bus.done; i++) begin
      @(negedge clk);
      nd++;
    end
    check("latched_done", int'(bus.done), 1);
    check("latched_degree", int'(bus.degree), 342);

    for (int c = 0; c < 2; c++) begin
      prev = 0;
      for (int v = 0; v < 1024; v++) begin
        do_search(v, c, deg);
        check("sweep", deg, golden(v, c));
        if (c == 0 && v > 0) check("monotone", int'(deg >= prev), 1);
        prev = deg;
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
